// File: rtl/mem_port_arbiter.sv
// Purpose : arbitrates a fetch port and a data port onto one shared memory port.
// Latency : request seen in IDLE at cycle 0, mem_req at cycle 1, ack one cycle after mem_ready.
// Backpressure: stall_if/stall_mem hold the pipeline until the owner's ack; a wait-cycle budget aborts stuck accesses.
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-low reset
//   if_req/if_addr           fetch request and byte address
//   if_rdata/if_ack          fetched word and one-cycle completion
//   dm_req/dm_we/dm_addr/dm_wdata   data request, write enable, address, store data
//   dm_rdata/dm_ack          load data and one-cycle completion
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready   shared memory port
//   stall_if/stall_mem       pipeline freeze requests
//   err                      sticky timeout flag
module mem_port_arbiter #(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        err
);

   localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } state_t;

   state_t        r_state;
   logic [WW-1:0] r_wait;
   logic          r_prev_data;   // 1 when the last grant went to the data port
   logic          r_mem_req;
   logic          r_mem_we;
   logic [31:0]   r_mem_addr;
   logic [31:0]   r_mem_wdata;
   logic [31:0]   r_if_rdata;
   logic [31:0]   r_dm_rdata;
   logic          r_if_ack;
   logic          r_dm_ack;
   logic          r_err;

   logic          w_turnaround;
   logic          w_grant_data;
   logic          w_grant_fetch;
   logic          w_timeout;
   logic          w_done;
   logic [31:0]   w_rdata;

   // An ack cycle is a dead cycle for arbitration, so a requester that still
   // holds req during its own ack is not granted a second time by mistake.
   assign w_turnaround  = r_if_ack | r_dm_ack;
   // Data wins ties unless it won the previous grant.
   assign w_grant_data  = ~w_turnaround & dm_req & ~(if_req & r_prev_data);
   assign w_grant_fetch = ~w_turnaround & if_req & ~w_grant_data;

   // This cycle would be the MAX_WAIT-th wait cycle: abort at its closing edge.
   assign w_timeout = ~mem_ready & (r_wait == WW'(MAX_WAIT - 1));
   assign w_done    = mem_ready | w_timeout;
   assign w_rdata   = mem_ready ? mem_rdata : 32'h0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_wait      <= '0;
         r_prev_data <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'h0;
         r_mem_wdata <= 32'h0;
         r_if_rdata  <= 32'h0;
         r_dm_rdata  <= 32'h0;
         r_if_ack    <= 1'b0;
         r_dm_ack    <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_if_ack <= 1'b0;
         r_dm_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_data) begin
                  r_state     <= DATA;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= dm_we;
                  r_mem_addr  <= dm_addr;
                  r_mem_wdata <= dm_wdata;
                  r_prev_data <= 1'b1;
                  r_wait      <= '0;
               end else if (w_grant_fetch) begin
                  r_state     <= FETCH;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= if_addr;
                  r_prev_data <= 1'b0;
                  r_wait      <= '0;
               end
            end
            FETCH: begin
               if (w_done) begin
                  r_state    <= IDLE;
                  r_mem_req  <= 1'b0;
                  r_mem_we   <= 1'b0;
                  r_if_rdata <= w_rdata;
                  r_if_ack   <= 1'b1;
                  if (!mem_ready) r_err <= 1'b1;
               end else begin
                  r_wait <= r_wait + WW'(1);
               end
            end
            DATA: begin
               if (w_done) begin
                  r_state   <= IDLE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_dm_ack  <= 1'b1;
                  // A completed store leaves load data alone; an abort always returns zero.
                  if (!(mem_ready && r_mem_we)) r_dm_rdata <= w_rdata;
                  if (!mem_ready) r_err <= 1'b1;
               end else begin
                  r_wait <= r_wait + WW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign if_rdata  = r_if_rdata;
   assign dm_rdata  = r_dm_rdata;
   assign if_ack    = r_if_ack;
   assign dm_ack    = r_dm_ack;
   assign err       = r_err;

   assign stall_mem = dm_req & ~r_dm_ack;
   assign stall_if  = (if_req & ~r_if_ack) | stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int MAXW = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = 32'h0;
   logic [31:0] dm_wdata = 32'h0;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ready = 1'b0;
   logic        stall_if;
   logic        stall_mem;
   logic        err;

   int n_checks = 0;
   int n_fail = 0;

   mem_port_arbiter #(.MAX_WAIT(MAXW)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // owner: 0 = nobody holds the memory, 1 = fetch port, 2 = data port
   int          m_owner = 0;
   int          m_waits = 0;
   logic        m_prev_dm = 1'b0;
   logic        m_if_ack = 1'b0;
   logic        m_dm_ack = 1'b0;
   logic        m_err = 1'b0;
   logic        m_we = 1'b0;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_wdata = 32'h0;
   logic [31:0] m_if_rdata = 32'h0;
   logic [31:0] m_dm_rdata = 32'h0;

   always @(posedge clk or negedge reset) begin
      logic        nif;
      logic        ndm;
      logic        done;
      logic [31:0] d;
      if (!reset) begin
         m_owner = 0; m_waits = 0; m_prev_dm = 1'b0;
         m_if_ack = 1'b0; m_dm_ack = 1'b0; m_err = 1'b0;
         m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
         m_if_rdata = 32'h0; m_dm_rdata = 32'h0;
      end else begin
         nif = 1'b0; ndm = 1'b0; done = 1'b0; d = 32'h0;
         if (m_owner == 0) begin
            if (!m_if_ack && !m_dm_ack) begin
               if (dm_req && !(if_req && m_prev_dm)) begin
                  m_owner = 2; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
                  m_prev_dm = 1'b1; m_waits = 0;
               end else if (if_req) begin
                  m_owner = 1; m_we = 1'b0; m_addr = if_addr;
                  m_prev_dm = 1'b0; m_waits = 0;
               end
            end
         end else begin
            if (mem_ready) begin
               d = mem_rdata; done = 1'b1;
            end else begin
               m_waits++;
               if (m_waits >= MAXW) begin
                  d = 32'h0; m_err = 1'b1; done = 1'b1;
               end
            end
            if (done) begin
               if (m_owner == 1) begin
                  m_if_rdata = d; nif = 1'b1;
               end else begin
                  if (!(mem_ready && m_we)) m_dm_rdata = d;
                  ndm = 1'b1;
               end
               m_owner = 0;
            end
         end
         m_if_ack = nif;
         m_dm_ack = ndm;
      end
   end

   // ---------------- per-cycle comparison against the model ----------------
   always @(negedge clk) begin
      logic exp_stall_mem;
      exp_stall_mem = dm_req & ~m_dm_ack;
      chk1("mem_req", mem_req, m_owner != 0);
      chk1("if_ack", if_ack, m_if_ack);
      chk1("dm_ack", dm_ack, m_dm_ack);
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("dm_rdata", dm_rdata, m_dm_rdata);
      chk1("err", err, m_err);
      chk1("stall_mem", stall_mem, exp_stall_mem);
      chk1("stall_if", stall_if, (if_req & ~m_if_ack) | exp_stall_mem);
      if (m_owner != 0) begin
         chk("mem_addr", mem_addr, m_addr);
         chk1("mem_we", mem_we, m_we);
      end
      if (m_owner == 2) chk("mem_wdata", mem_wdata, m_wdata);
   end

   // Advance to the next cycle; inputs change 2 time units after the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------- directed stimulus with literal expectations ----------------
   initial begin
      #1 reset = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_dm_rdata", dm_rdata, 32'h0);
      chk1("rst_err", err, 1'b0);
      tick();
      reset = 1'b1;
      tick();

      // fetch only, memory ready immediately
      tick();
      if_req = 1'b1; if_addr = 32'h0040_0004; mem_ready = 1'b1; mem_rdata = 32'h8C08_0000;
      @(negedge clk); chk1("f_stall_c0", stall_if, 1'b1);
      tick();
      @(negedge clk); chk1("f_req_c1", mem_req, 1'b1);
      chk("f_addr_c1", mem_addr, 32'h0040_0004); chk1("f_stall_c1", stall_if, 1'b1);
      tick();
      @(negedge clk); chk1("f_ack_c2", if_ack, 1'b1);
      chk("f_rdata_c2", if_rdata, 32'h8C08_0000); chk1("f_stall_c2", stall_if, 1'b0);
      tick(); if_req = 1'b0; mem_ready = 1'b0;
      tick();

      // simultaneous requests after reset: data, then fetch, then data
      reset = 1'b0; tick(); reset = 1'b1; tick();
      if_req = 1'b1; if_addr = 32'h0040_0010;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0000;
      mem_ready = 1'b1; mem_rdata = 32'hAAAA_0001;
      tick();
      @(negedge clk); chk("arb1_addr", mem_addr, 32'h1001_0000); chk1("arb1_req", mem_req, 1'b1);
      tick();
      @(negedge clk); chk1("arb1_dack", dm_ack, 1'b1); chk("arb1_drd", dm_rdata, 32'hAAAA_0001);
      chk1("arb1_turn", mem_req, 1'b0);
      tick(); mem_rdata = 32'hBBBB_0002;
      @(negedge clk); chk1("arb2_idle", mem_req, 1'b0);
      tick();
      @(negedge clk); chk("arb2_addr", mem_addr, 32'h0040_0010); chk1("arb2_we", mem_we, 1'b0);
      tick(); if_req = 1'b0;
      @(negedge clk); chk1("arb2_iack", if_ack, 1'b1); chk("arb2_ird", if_rdata, 32'hBBBB_0002);
      chk1("b2b_ackcyc", mem_req, 1'b0);
      tick();
      @(negedge clk); chk1("b2b_idle", mem_req, 1'b0);
      tick();
      @(negedge clk); chk1("b2b_req", mem_req, 1'b1); chk("arb3_addr", mem_addr, 32'h1001_0000);
      tick(); dm_req = 1'b0;
      @(negedge clk); chk1("arb3_dack", dm_ack, 1'b1);
      tick(); mem_ready = 1'b0;

      // store with three wait cycles
      tick();
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0008; dm_wdata = 32'h1234_5678;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 4) mem_ready = 1'b1;
         @(negedge clk);
         chk1("st_req", mem_req, 1'b1); chk1("st_we", mem_we, 1'b1);
         chk("st_addr", mem_addr, 32'h1001_0008); chk("st_wdata", mem_wdata, 32'h1234_5678);
         chk1("st_noack", dm_ack, 1'b0);
      end
      tick(); dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
      @(negedge clk); chk1("st_ack_c5", dm_ack, 1'b1); chk("st_drd_kept", dm_rdata, 32'hBBBB_0002);
      tick();

      // timeout: memory never answers
      tick();
      if_req = 1'b1; if_addr = 32'h0040_0020; mem_rdata = 32'hDEAD_BEEF;
      for (int i = 1; i <= MAXW; i++) begin
         tick();
         @(negedge clk); chk1("to_wait_req", mem_req, 1'b1); chk1("to_wait_noack", if_ack, 1'b0);
      end
      tick(); if_req = 1'b0;
      @(negedge clk); chk1("to_ack", if_ack, 1'b1); chk("to_rdata", if_rdata, 32'h0);
      chk1("to_err", err, 1'b1);
      tick();
      tick();
      if_req = 1'b1; if_addr = 32'h0040_0024; mem_ready = 1'b1; mem_rdata = 32'h0102_0304;
      tick();
      tick(); if_req = 1'b0;
      @(negedge clk); chk1("post_to_ack", if_ack, 1'b1); chk("post_to_rd", if_rdata, 32'h0102_0304);
      chk1("err_sticky", err, 1'b1);
      tick(); mem_ready = 1'b0;
      tick();

      // reset in the middle of a data read
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0010;
      tick();
      @(negedge clk); chk1("rx_req_c1", mem_req, 1'b1);
      tick();
      reset = 1'b0; dm_req = 1'b0;
      #1 chk1("rx_req_drop", mem_req, 1'b0);
      @(negedge clk); chk1("rx_no_dack", dm_ack, 1'b0); chk1("rx_err_clr", err, 1'b0);
      tick(); reset = 1'b1;
      tick();
      if_req = 1'b1; if_addr = 32'h0040_0030; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      @(negedge clk); chk("rx_f_addr", mem_addr, 32'h0040_0030); chk1("rx_f_req", mem_req, 1'b1);
      tick(); if_req = 1'b0;
      @(negedge clk); chk1("rx_f_ack", if_ack, 1'b1); chk("rx_f_rd", if_rdata, 32'hCAFE_F00D);
      chk1("rx_no_dack2", dm_ack, 1'b0);
      tick(); mem_ready = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
